// File: rtl/execute.sv
// EX stage of the 5-stage MIPS pipeline: operand select, ALU control decode,
// ALU, destination select and the EX/MEM pipeline register.
module execute #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             iSig_RegDst,
    input  logic [1:0]       iSig_ALUOp,
    input  logic             iSig_ALUSrc,
    input  logic [WIDTH-1:0] iadder_branch_result,
    input  logic [WIDTH-1:0] iregfile_read_1,
    input  logic [WIDTH-1:0] iregfile_read_2,
    input  logic [WIDTH-1:0] iimm,
    input  logic [REGW-1:0]  iins2016,
    input  logic [REGW-1:0]  iins1511,
    output logic [WIDTH-1:0] o_adder_branch_result,
    output logic             oALU_zero,
    output logic [WIDTH-1:0] oALU_result,
    output logic [WIDTH-1:0] oregfile_read_2,
    output logic [REGW-1:0]  oreg_write_reg
);

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_NONE
    } aluOp_t;

    aluOp_t           w_aluOp;
    logic [WIDTH-1:0] w_opA;
    logic [WIDTH-1:0] w_opB;
    logic [4:0]       w_shamt;
    logic [5:0]       w_funct;
    logic [WIDTH-1:0] w_aluResult;
    logic             w_aluZero;
    logic [REGW-1:0]  w_writeReg;

    assign w_opA      = iregfile_read_1;
    assign w_opB      = iSig_ALUSrc ? iimm : iregfile_read_2;
    assign w_funct    = iimm[5:0];
    assign w_shamt    = iimm[10:6];
    assign w_writeReg = iSig_RegDst ? iins1511 : iins2016;
    assign w_aluZero  = (w_aluResult == '0);

    // Decode the main-control ALUOp class (and funct for R-type) into one ALU operation.
    always_comb begin
        w_aluOp = ALU_NONE;
        case (iSig_ALUOp)
            2'b00: w_aluOp = ALU_ADD;
            2'b01: w_aluOp = ALU_SUB;
            2'b11: w_aluOp = ALU_OR;
            default: begin
                case (w_funct)
                    6'b100000, 6'b100001: w_aluOp = ALU_ADD;
                    6'b100010, 6'b100011: w_aluOp = ALU_SUB;
                    6'b100100:            w_aluOp = ALU_AND;
                    6'b100101:            w_aluOp = ALU_OR;
                    6'b100110:            w_aluOp = ALU_XOR;
                    6'b100111:            w_aluOp = ALU_NOR;
                    6'b101010:            w_aluOp = ALU_SLT;
                    6'b101011:            w_aluOp = ALU_SLTU;
                    6'b000000:            w_aluOp = ALU_SLL;
                    6'b000010:            w_aluOp = ALU_SRL;
                    6'b000011:            w_aluOp = ALU_SRA;
                    default:              w_aluOp = ALU_NONE;
                endcase
            end
        endcase
    end

    // ALU datapath; wraps modulo 2^WIDTH, shifts always act on operand B.
    always_comb begin
        w_aluResult = '0;
        case (w_aluOp)
            ALU_ADD:  w_aluResult = w_opA + w_opB;
            ALU_SUB:  w_aluResult = w_opA - w_opB;
            ALU_AND:  w_aluResult = w_opA & w_opB;
            ALU_OR:   w_aluResult = w_opA | w_opB;
            ALU_XOR:  w_aluResult = w_opA ^ w_opB;
            ALU_NOR:  w_aluResult = ~(w_opA | w_opB);
            ALU_SLT:  w_aluResult = {{(WIDTH-1){1'b0}}, ($signed(w_opA) < $signed(w_opB))};
            ALU_SLTU: w_aluResult = {{(WIDTH-1){1'b0}}, (w_opA < w_opB)};
            ALU_SLL:  w_aluResult = w_opB << w_shamt;
            ALU_SRL:  w_aluResult = w_opB >> w_shamt;
            ALU_SRA:  w_aluResult = $signed(w_opB) >>> w_shamt;
            default:  w_aluResult = '0;
        endcase
    end

    // EX/MEM pipeline register: loads every cycle, synchronous reset wins over the load.
    always_ff @(posedge clk) begin
        if (rstn) begin
            o_adder_branch_result <= '0;
            oALU_zero             <= 1'b0;
            oALU_result           <= '0;
            oregfile_read_2       <= '0;
            oreg_write_reg        <= '0;
        end else begin
            o_adder_branch_result <= iadder_branch_result;
            oALU_zero             <= w_aluZero;
            oALU_result           <= w_aluResult;
            oregfile_read_2       <= iregfile_read_2;
            oreg_write_reg        <= w_writeReg;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the execute stage: a behavioural model predicts the
// EX/MEM register contents one edge after each vector, and directed vectors
// pin the model with hand-computed literals.
module tb_execute;

    logic        clk;
    logic        rstn;
    logic        regDst;
    logic [1:0]  aluOpIn;
    logic        aluSrc;
    logic [31:0] branchIn;
    logic [31:0] read1;
    logic [31:0] read2;
    logic [31:0] imm;
    logic [4:0]  rtIdx;
    logic [4:0]  rdIdx;
    logic [31:0] branchOut;
    logic        zeroOut;
    logic [31:0] resultOut;
    logic [31:0] read2Out;
    logic [4:0]  writeRegOut;

    typedef struct {
        logic [31:0] br;
        logic [31:0] res;
        logic [31:0] rd2;
        logic        z;
        logic [4:0]  wr;
    } expect_t;

    expect_t expQ[$];
    int assertCount = 0;
    int failCount   = 0;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_BAD  = 6'b111111;

    execute #(.WIDTH(32), .REGW(5)) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .iSig_RegDst           (regDst),
        .iSig_ALUOp            (aluOpIn),
        .iSig_ALUSrc           (aluSrc),
        .iadder_branch_result  (branchIn),
        .iregfile_read_1       (read1),
        .iregfile_read_2       (read2),
        .iimm                  (imm),
        .iins2016              (rtIdx),
        .iins1511              (rdIdx),
        .o_adder_branch_result (branchOut),
        .oALU_zero             (zeroOut),
        .oALU_result           (resultOut),
        .oregfile_read_2       (read2Out),
        .oreg_write_reg        (writeRegOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Arithmetic model of the ALU written from the instruction semantics.
    function automatic logic [31:0] modelAlu(input logic [1:0] op, input logic [5:0] funct,
                                             input int shamt, input logic [31:0] a,
                                             input logic [31:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint p2 = longint'(1) << shamt;
        logic [63:0] ext;
        if (op == 2'b00) return 32'(ua + ub);
        if (op == 2'b01) return 32'(ua - ub);
        if (op == 2'b11) return a | b;
        case (funct)
            F_ADD, F_ADDU:       return 32'(ua + ub);
            F_SUB, 6'b100011:    return 32'(ua - ub);
            F_AND:               return a & b;
            F_OR:                return a | b;
            F_XOR:               return a ^ b;
            F_NOR:               return ~(a | b);
            F_SLT:               return (sa < sb) ? 32'd1 : 32'd0;
            F_SLTU:              return (ua < ub) ? 32'd1 : 32'd0;
            F_SLL:               return 32'(ub * p2);
            F_SRL:               return 32'(ub / p2);
            F_SRA: begin
                ext = {{32{b[31]}}, b};
                ext = ext >> shamt;
                return ext[31:0];
            end
            default:             return 32'd0;
        endcase
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one vector, let one edge sample it, and queue what the model says must appear.
    task automatic applyStimulus(input logic rst, input logic [1:0] op, input logic src,
                                 input logic dst, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] im, input logic [31:0] br,
                                 input logic [4:0] rt, input logic [4:0] rd);
        expect_t e;
        logic [31:0] opB;
        rstn     = rst;
        aluOpIn  = op;
        aluSrc   = src;
        regDst   = dst;
        read1    = a;
        read2    = b;
        imm      = im;
        branchIn = br;
        rtIdx    = rt;
        rdIdx    = rd;
        opB      = src ? im : b;
        if (rst) begin
            e.br = '0; e.res = '0; e.rd2 = '0; e.z = 1'b0; e.wr = '0;
        end else begin
            e.br  = br;
            e.res = modelAlu(op, im[5:0], int'(im[10:6]), a, opB);
            e.rd2 = b;
            e.z   = (e.res == 32'd0);
            e.wr  = dst ? rd : rt;
        end
        @(posedge clk);
        expQ.push_back(e);
        #1;
    endtask

    // Literal checks right after the edge that loaded the last vector.
    task automatic checkOutput(input string name, input logic [31:0] expRes,
                               input logic expZero, input logic [4:0] expReg);
        check32({name, " result"}, resultOut, expRes);
        check32({name, " zero"}, {31'd0, zeroOut}, {31'd0, expZero});
        check32({name, " write_reg"}, {27'd0, writeRegOut}, {27'd0, expReg});
    endtask

    function automatic logic [31:0] rImm(input logic [5:0] funct, input logic [4:0] shamt);
        return {21'd0, shamt, funct};
    endfunction

    // Compare every queued model prediction against the registered outputs.
    always @(negedge clk) begin
        expect_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check32("model result", resultOut, e.res);
            check32("model zero", {31'd0, zeroOut}, {31'd0, e.z});
            check32("model branch", branchOut, e.br);
            check32("model read_2", read2Out, e.rd2);
            check32("model write_reg", {27'd0, writeRegOut}, {27'd0, e.wr});
        end
    end

    initial begin
        logic [5:0] functs[14];
        logic [5:0] f;
        functs = '{F_ADD, F_ADDU, F_SUB, 6'b100011, F_AND, F_OR, F_XOR, F_NOR,
                   F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_BAD};

        rstn = 1'b1; aluOpIn = 2'b00; aluSrc = 1'b0; regDst = 1'b0;
        read1 = '0; read2 = '0; imm = '0; branchIn = '0; rtIdx = '0; rdIdx = '0;

        // Reset held for two edges with nonzero inputs
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b1, 32'hDEADBEEF, 32'h1234_5678, 32'h0000_0025,
                      32'h0040_0000, 5'd9, 5'd10);
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b1, 32'hDEADBEEF, 32'h1234_5678, 32'h0000_0025,
                      32'h0040_0000, 5'd9, 5'd10);
        checkOutput("reset", 32'd0, 1'b0, 5'd0);
        check32("reset branch", branchOut, 32'd0);
        check32("reset read_2", read2Out, 32'd0);

        // Load address: 0x1000 + (-4)
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0077, 32'hFFFF_FFFC,
                      32'h0000_0000, 5'd5, 5'd12);
        checkOutput("lw addr", 32'h0000_0FFC, 1'b0, 5'd5);

        // beq compare of equal registers
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'h0000_0008,
                      32'h0040_0020, 5'd3, 5'd4);
        checkOutput("beq", 32'd0, 1'b1, 5'd3);
        check32("beq branch", branchOut, 32'h0040_0020);
        check32("beq read_2", read2Out, 32'h1234_5678);

        // ori-style immediate OR; read_2 passes through unchanged, not operand B
        applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 32'h0000_F000, 32'hAAAA_5555, 32'h0000_00FF,
                      32'h0000_0004, 5'd8, 5'd1);
        checkOutput("ori", 32'h0000_F0FF, 1'b0, 5'd8);
        check32("ori read_2", read2Out, 32'hAAAA_5555);

        // R-type sweep with A = -1, B = 1
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, rImm(F_ADD, 5'd0), 32'h0, 5'd2, 5'd17);
        checkOutput("add", 32'd0, 1'b1, 5'd17);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, rImm(F_SUB, 5'd0), 32'h0, 5'd2, 5'd17);
        checkOutput("sub", 32'hFFFF_FFFE, 1'b0, 5'd17);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, rImm(F_AND, 5'd0), 32'h0, 5'd2, 5'd17);
        checkOutput("and", 32'h1, 1'b0, 5'd17);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, rImm(F_OR, 5'd0), 32'h0, 5'd2, 5'd17);
        checkOutput("or", 32'hFFFF_FFFF, 1'b0, 5'd17);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, rImm(F_XOR, 5'd0), 32'h0, 5'd2, 5'd17);
        checkOutput("xor", 32'hFFFF_FFFE, 1'b0, 5'd17);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, rImm(F_NOR, 5'd0), 32'h0, 5'd2, 5'd17);
        checkOutput("nor", 32'd0, 1'b1, 5'd17);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, rImm(F_SLT, 5'd0), 32'h0, 5'd2, 5'd17);
        checkOutput("slt", 32'd1, 1'b0, 5'd17);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, rImm(F_SLTU, 5'd0), 32'h0, 5'd2, 5'd17);
        checkOutput("sltu", 32'd0, 1'b1, 5'd17);

        // Shifts of 0x80000000 by 4
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b1, 32'h0, 32'h8000_0000, rImm(F_SLL, 5'd4), 32'h0, 5'd2, 5'd6);
        checkOutput("sll", 32'd0, 1'b1, 5'd6);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b1, 32'h0, 32'h8000_0000, rImm(F_SRL, 5'd4), 32'h0, 5'd2, 5'd6);
        checkOutput("srl", 32'h0800_0000, 1'b0, 5'd6);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b1, 32'h0, 32'h8000_0000, rImm(F_SRA, 5'd4), 32'h0, 5'd2, 5'd6);
        checkOutput("sra", 32'hF800_0000, 1'b0, 5'd6);

        // Signed overflow wraps silently; undefined funct gives zero
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h1, rImm(F_ADD, 5'd0), 32'h0, 5'd21, 5'd22);
        checkOutput("add overflow", 32'h8000_0000, 1'b0, 5'd21);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, rImm(F_BAD, 5'd3), 32'h0, 5'd21, 5'd22);
        checkOutput("bad funct", 32'd0, 1'b1, 5'd22);

        // Back-to-back changing vectors, checked against the model each edge
        for (int i = 0; i < 40; i++) begin
            f = functs[$urandom_range(13, 0)];
            applyStimulus(1'b0, 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                          1'($urandom_range(1, 0)), $urandom, $urandom,
                          {$urandom_range(65535, 0) << 16, 5'($urandom_range(31, 0)), 5'd0, f},
                          $urandom, 5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)));
        end

        // Reset mid-stream must clear on the very next edge
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, 32'h5, 32'h6, 32'h7, 32'h8, 5'd1, 5'd2);
        checkOutput("mid reset", 32'd0, 1'b0, 5'd0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 32'h5, 32'h6, 32'h7, 32'h8, 5'd1, 5'd2);
        checkOutput("after reset", 32'h0000_000B, 1'b0, 5'd2);

        for (int i = 0; i < 5 && expQ.size() != 0; i++) @(negedge clk);
        #1;
        assertCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/execute.md
Name: execute

Overview:
- EX stage of the 5-stage MIPS pipeline.
- Selects the ALU second operand and decodes ALUOp/funct into an ALU operation.
- Computes the 32-bit result and zero flag, and selects the destination register.
- Captures everything, plus the forwarded branch target and store data, in the EX/MEM pipeline register that feeds the MEM stage.

Parameters:
- WIDTH, 32, datapath width
- REGW, 5, register-index width

Ports:
- clk  in  1  stage clock; all state updates on rising edge
- rstn  in  1  reset, synchronous, active-high (despite the name)
- iSig_RegDst  in  1  destination select: 1 = rd (iins1511), 0 = rt (iins2016)
- iSig_ALUOp  in  2  ALU operation class from main control
- iSig_ALUSrc  in  1  ALU operand B select: 1 = iimm, 0 = iregfile_read_2
- iadder_branch_result  in  32  branch target from ID stage
- iregfile_read_1  in  32  rs value, ALU operand A
- iregfile_read_2  in  32  rt value
- iimm  in  32  sign-extended immediate; [5:0] = funct, [10:6] = shamt
- iins2016  in  5  instruction rt field
- iins1511  in  5  instruction rd field
- o_adder_branch_result  out  32  registered branch target
- oALU_zero  out  1  registered zero flag
- oALU_result  out  32  registered ALU result
- oregfile_read_2  out  32  registered rt value (store data)
- oreg_write_reg  out  5  registered destination register index

Behaviour:
- Single clock, all outputs registered, 1-cycle latency: inputs sampled at edge N appear on outputs after edge N.
- No handshake and no stall/enable; the register loads every cycle.
- Reset: when rstn = 1 at a rising edge, all outputs become 0 on that edge. Reset has priority over the data load. Input values during the reset cycle are discarded.
- Operand selection: A = iregfile_read_1; B = iSig_ALUSrc ? iimm : iregfile_read_2.
- ALU control decode:
  - ALUOp 00: ADD (load/store address)
  - ALUOp 01: SUB (beq compare)
  - ALUOp 11: OR (immediate logical)
  - ALUOp 10: R-type, decoded from funct = iimm[5:0]:
    - 100000 / 100001: ADD
    - 100010 / 100011: SUB
    - 100100: AND
    - 100101: OR
    - 100110: XOR
    - 100111: NOR
    - 101010: SLT, signed
    - 101011: SLTU, unsigned
    - 000000: SLL B by iimm[10:6]
    - 000010: SRL B by iimm[10:6], logical
    - 000011: SRA B by iimm[10:6], arithmetic
    - any other funct: result 0
- Arithmetic: modulo 2^32 wrap; no overflow detection or exception.
- SLT/SLTU result is 32'd1 or 32'd0.
- Zero flag = (ALU result == 0), computed combinationally and registered with the result.
- Destination: oreg_write_reg = iSig_RegDst ? iins1511 : iins2016.
- Pass-through: iadder_branch_result and iregfile_read_2 (pre-mux value, not B) are registered unchanged.
- X-free: decode is fully specified for all 2-bit ALUOp and 6-bit funct values.

Test Plan:
- Reset: drive nonzero inputs with rstn = 1 for 2 edges -> all outputs 0. Release rstn; next edge -> outputs reflect inputs.
- Load address: ALUOp = 00, ALUSrc = 1, read_1 = 0x00001000, imm = 0xFFFFFFFC, RegDst = 0, ins2016 = 5.
  -> result 0x00000FFC, zero = 0, write_reg = 5, after 1 edge.
- beq: ALUOp = 01, ALUSrc = 0, read_1 = read_2 = 0x12345678, branch = 0x00400020.
  -> result 0, zero = 1, o_adder_branch_result = 0x00400020, oregfile_read_2 = 0x12345678.
- R-type sweep: ALUOp = 10, ALUSrc = 0, RegDst = 1, ins1511 = 17, A = 0xFFFFFFFF (-1), B = 0x00000001:
  - add -> 0, zero = 1
  - sub -> 0xFFFFFFFE
  - and -> 1
  - or -> 0xFFFFFFFF
  - nor -> 0
  - slt -> 1
  - sltu -> 0
  - write_reg = 17 throughout
- Shifts: ALUOp = 10, B = 0x80000000, shamt = 4:
  - sll -> 0
  - srl -> 0x08000000
  - sra -> 0xF8000000
- Overflow and undefined funct:
  - ADD of 0x7FFFFFFF + 1 -> 0x80000000, no flag.
  - Undefined funct 111111 -> result 0, zero = 1.
  - Back-to-back changing inputs each cycle -> each result appears exactly one edge later.
